axi4lite_regfile: RTL and testbench
===================================

Name: axi4lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file. Successor to the fixed 8 × 32-bit AXI4-Lite slave.
- Adds the following, none of which the previous slave has:
  - configurable register count and data width;
  - byte write strobes;
  - per-register read-only masking;
  - DECERR/SLVERR responses;
  - a hardware-side update port per register.
- Sits between an AXI4-Lite master (CPU or bench master) and peripheral control/status logic.

Parameters:
- ADDR_W, 8, byte-address width of AWADDR/ARADDR.
- DW, 32, data width. Must be 32 or 64.
- NREGS, 16, number of registers. Must satisfy 1 ≤ NREGS ≤ 2^(ADDR_W - log2(DW/8)).
- RO_MASK, '0 (NREGS bits), bit i = 1 makes register i read-only from the bus (status register).
- RST_VAL, '0 (NREGS × DW bits), reset value of each register.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DW  write data.
- wstrb  in  DW/8  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DW  read data.
- rresp  out  2  read response.
- rvalid  out  1  read response valid.
- rready  in  1  read response ready.
- hw_we  in  NREGS  per-register hardware write enable.
- hw_wdata  in  NREGS×DW  hardware write data, register i at slice [i*DW +: DW].
- regs  out  NREGS×DW  current register contents, same packing as hw_wdata.

Behaviour:
- **Reset.** On a clk edge with reset_n = 0:
  - regs = RST_VAL;
  - awready, wready, arready, bvalid, rvalid = 0;
  - bresp, rresp = 2'b00; rdata = 0.
- **After reset.** awready, wready and arready are 1 on the first cycle after reset_n returns to 1.
- **Address decode.**
  - Register index = addr[ADDR_W-1 : log2(DW/8)].
  - Low byte-offset bits are ignored.
  - Index ≥ NREGS → DECERR (2'b11).
- **Write channel; AW and W are independent.**
  - Each has a one-entry holding register.
  - awready = ~aw_held; wready = ~w_held. The address or data is captured on handshake.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens in the cycle where both are held (or arriving) and bvalid = 0 (or bvalid & bready).
  - At commit: bytes with wstrb = 1 are updated, bvalid = 1 next cycle, and both holding registers clear.
  - Latency: AW+W handshake together at edge N → regs updated and bvalid = 1 at N+1. awready/wready return to 1 at N+1.
  - bvalid holds until bready. bresp is stable while bvalid = 1.
  - bresp values:
    - OKAY (00) for a normal write;
    - SLVERR (10) for a write to a RO_MASK register, which leaves contents unchanged;
    - DECERR (11) for an out-of-range index, which writes nothing.
  - wstrb = 0 → OKAY, no change.
- **Read channel.**
  - arready = ~rvalid | rready, which gives back-to-back reads of one per cycle.
  - An AR handshake at edge N gives rvalid = 1 and registered rdata/rresp at N+1.
  - rdata and rresp hold while rvalid & ~rready.
  - Out-of-range reads return rdata = 0 with rresp = DECERR.
  - RO registers read normally with OKAY.
- **Hardware port.** hw_we[i] = 1 loads hw_wdata slice i into register i at the next edge, whether or not register i is RO.
- **Simultaneous bus commit and hw_we on the same register.**
  - RO register: hw wins (the bus write is ignored anyway).
  - RW register: bus-strobed bytes win; unstrobed bytes take hw_wdata.
- **Read/write collision.** A read handshaking in the same cycle as a write commit to the same register returns the old value.
- **Reset mid-transaction.** All held AW/W entries and pending B/R responses are discarded with no response issued. The master must restart.
- **Ready/valid rules.** Ready never depends combinationally on valid of the same channel, and valid is never retracted before handshake.

Test Plan:
- **Reset values.** Reset with RST_VAL[3] = 32'hDEAD_BEEF → regs slice 3 = DEADBEEF; all valids 0. Read addr 0x0C → rdata DEADBEEF, rresp 00.
- **Write order and strobes.** AW before W by 3 cycles; W before AW; then same-cycle AW/W to addr 0x08 with wdata 0x11223344, wstrb 4'b0101, where register 2 was 0xAABBCCDD → register 2 = 0xAA22CC44. Each write gets exactly one bvalid with OKAY.
- **Error responses.** Write to addr 0x40 with NREGS = 16 → DECERR, no register changes. Write to RO_MASK bit 5 (addr 0x14) → SLVERR, register 5 unchanged. Read addr 0x40 → rdata 0, rresp DECERR.
- **Backpressure.** Hold bready = 0 for 5 cycles → bvalid and bresp stable, awready/wready stay 0 after the next AW/W is captured. Hold rready = 0 with arvalid = 1 → arready = 0, rdata stable. Then rready = 1 with 4 back-to-back ARs → 4 consecutive rvalid beats.
- **Hardware/bus collision.** hw_we[1] with 0xFFFF_FFFF and a bus write of 0 with wstrb 4'b0011 to register 1 in the same commit cycle → register 1 = 0xFFFF_0000.
- **Read/write collision.** An AR to register 2 handshaking in the same cycle as a write commit to register 2 returns the pre-write value.
- **Reset mid-transaction.** Assert reset_n = 0 while bvalid = 1 → bvalid = 0 next cycle and regs = RST_VAL.

Source files
------------

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, read-only status registers,
// SLVERR/DECERR responses and a per-register hardware update port.
module axi4lite_regfile #(
    parameter int                      ADDR_W  = 8,
    parameter int                      DW      = 32,
    parameter int                      NREGS   = 16,
    parameter logic [NREGS-1:0]        RO_MASK = '0,
    parameter logic [NREGS*DW-1:0]     RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DW-1:0]         wdata,
    input  logic [DW/8-1:0]       wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DW-1:0]         rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [NREGS-1:0]      hw_we,
    input  logic [NREGS*DW-1:0]   hw_wdata,
    output logic [NREGS*DW-1:0]   regs
);
    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = ADDR_W - LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic              aw_held_reg;
    logic [ADDR_W-1:0] aw_addr_reg;
    logic              w_held_reg;
    logic [DW-1:0]     w_data_reg;
    logic [SW-1:0]     w_strb_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;
    logic [DW-1:0]     rdata_reg;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_strb;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range, wr_ro;
    logic [1:0]        wr_resp;
    logic [DW-1:0]     rd_val;
    logic [DW-1:0]     reg_arr [NREGS];
    logic              unused_low_bits;

    // Readies are gated by reset_n so they read 0 while reset is held.
    assign awready = reset_n & ~aw_held_reg;
    assign wready  = reset_n & ~w_held_reg;
    assign arready = reset_n & (~rvalid_reg | rready);

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // A write can commit straight from the bus without passing through the holding registers.
    assign wr_addr = aw_held_reg ? aw_addr_reg : awaddr;
    assign wr_data = w_held_reg ? w_data_reg : wdata;
    assign wr_strb = w_held_reg ? w_strb_reg : wstrb;
    assign commit  = (aw_held_reg | aw_hs) & (w_held_reg | w_hs) & (~bvalid_reg | bready);

    assign wr_idx          = wr_addr[ADDR_W-1:LSB];
    assign rd_idx          = araddr[ADDR_W-1:LSB];
    assign wr_in_range     = 32'(wr_idx) < NREGS;
    assign rd_in_range     = 32'(rd_idx) < NREGS;
    assign unused_low_bits = ^{wr_addr[LSB-1:0], araddr[LSB-1:0]};

    always_comb begin
        wr_ro  = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (32'(wr_idx) == i) wr_ro = RO_MASK[i];
            if (32'(rd_idx) == i) rd_val = reg_arr[i];
        end
    end

    assign wr_resp = !wr_in_range ? RESP_DECERR : (wr_ro ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            if (commit)     aw_held_reg <= 1'b0;
            else if (aw_hs) aw_held_reg <= 1'b1;
            if (aw_hs)      aw_addr_reg <= awaddr;

            if (commit)     w_held_reg <= 1'b0;
            else if (w_hs)  w_held_reg <= 1'b1;
            if (w_hs) begin
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end

            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_resp;
            end else if (bready) begin
                bvalid_reg <= 1'b0;
            end

            // rd_val sees the pre-edge contents, so a colliding read returns the old value.
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_in_range ? rd_val : '0;
                rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
            end else if (rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign bvalid = bvalid_reg;
    assign bresp  = bresp_reg;
    assign rvalid = rvalid_reg;
    assign rresp  = rresp_reg;
    assign rdata  = rdata_reg;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [DW-1:0] val_reg, val_next;
        logic          bus_hit;

        assign bus_hit = commit && (32'(wr_idx) == gi) && !RO_MASK[gi];

        // Hardware load first, then strobed bus bytes override it.
        always_comb begin
            val_next = val_reg;
            if (hw_we[gi]) val_next = hw_wdata[gi*DW +: DW];
            if (bus_hit) begin
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) val_next[b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) val_reg <= RST_VAL[gi*DW +: DW];
            else          val_reg <= val_next;
        end

        assign regs[gi*DW +: DW] = val_reg;
        assign reg_arr[gi]       = val_reg;
    end
endmodule

// File: tb/tb_axi4lite_regfile.sv
// Self-checking bench for axi4lite_regfile: directed scenarios plus random
// bus/hardware traffic checked against an array-based register model.
module tb_axi4lite_regfile;
    localparam int ADDR_W = 8;
    localparam int DW     = 32;
    localparam int NREGS  = 16;
    localparam logic [NREGS-1:0]    RO   = 16'h0020;
    localparam logic [NREGS*DW-1:0] RSTV = (512'hDEADBEEF << 96) | (512'hAABBCCDD << 64);

    logic                clk = 1'b0;
    logic                reset_n;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic                awvalid, wvalid, bready, arvalid, rready;
    logic                awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]       wdata, rdata;
    logic [DW/8-1:0]     wstrb;
    logic [1:0]          bresp, rresp;
    logic [NREGS-1:0]    hw_we;
    logic [NREGS*DW-1:0] hw_wdata, regs;

    axi4lite_regfile #(
        .ADDR_W(ADDR_W), .DW(DW), .NREGS(NREGS), .RO_MASK(RO), .RST_VAL(RSTV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .regs(regs)
    );

    always #5 clk = ~clk;

    logic [31:0] model [NREGS];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_vec();
        logic [511:0] v = '0;
        for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = RSTV[i*32 +: 32];
    endfunction

    // Bus write as seen by software: word index from address, strobed bytes only.
    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx >= NREGS) return 2'b11;
        if (RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recv_b(input logic [1:0] exp, input string tag);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin tick(); n++; end
        check({tag, "_blat"}, 32'(n), 32'd0);
        check({tag, "_bvalid"}, bvalid, 1'b1);
        check({tag, "_bresp"}, bresp, exp);
        tick();
        bready = 1'b0;
        check({tag, "_bonce"}, bvalid, 1'b0);
        check({tag, "_regs"}, regs, model_vec());
    endtask

    // mode 0: AW and W together; 1: AW first; 2: W first. gap = idle cycles between.
    task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input int gap, input string tag);
        logic [1:0] exp;
        int n = 0;
        exp = model_write(a, d, s);
        awaddr = a; wdata = d; wstrb = s;
        if (mode == 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            while (!(awready && wready) && n < 50) begin tick(); n++; end
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (mode == 1) begin
            awvalid = 1'b1;
            while (!awready && n < 50) begin tick(); n++; end
            tick();
            awvalid = 1'b0;
            check({tag, "_awheld"}, awready, 1'b0);
            repeat (gap) tick();
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end else begin
            wvalid = 1'b1;
            while (!wready && n < 50) begin tick(); n++; end
            tick();
            wvalid = 1'b0;
            check({tag, "_wheld"}, wready, 1'b0);
            repeat (gap) tick();
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end
        check({tag, "_hs_wait"}, 32'(n), 32'd0);
        recv_b(exp, tag);
    endtask

    task automatic read_txn(input logic [7:0] a, input string tag);
        int idx = int'(a) / 4;
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, rvalid, 1'b1);
        check({tag, "_rdata"}, rdata, (idx < NREGS) ? model[idx] : 32'h0);
        check({tag, "_rresp"}, rresp, (idx < NREGS) ? 2'b00 : 2'b11);
        tick();
        rready = 1'b0;
        check({tag, "_rdone"}, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  e1, e2;
        logic [31:0] old, v;
        int          k;

        reset_n = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; hw_we = '0; hw_wdata = '0;
        repeat (3) tick();
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_awready", awready, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_reg3", regs[96 +: 32], 32'hDEADBEEF);
        check("rst_regs", regs, RSTV);
        reset_n = 1'b1;
        #1;
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wready", wready, 1'b1);
        check("post_rst_arready", arready, 1'b1);
        model_reset();
        tick();

        read_txn(8'h0C, "rd_rst3");
        write_txn(8'h1C, 32'h01234567, 4'hF, 1, 3, "aw_first");
        write_txn(8'h18, 32'h89ABCDEF, 4'hF, 2, 2, "w_first");
        write_txn(8'h08, 32'h11223344, 4'b0101, 0, 0, "same_cyc");
        check("strb_reg2", regs[64 +: 32], 32'hAA22CC44);
        write_txn(8'h40, 32'h55555555, 4'hF, 0, 0, "wr_decerr");
        write_txn(8'h14, 32'h66666666, 4'hF, 0, 0, "wr_slverr");
        write_txn(8'h10, 32'h77777777, 4'h0, 0, 0, "wr_nostrb");
        read_txn(8'h40, "rd_decerr");
        read_txn(8'h14, "rd_ro");

        // Write backpressure: first response held, second write captured but blocked.
        e1 = model_write(8'h1C, 32'h0BADF00D, 4'hF);
        awaddr = 8'h1C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bvalid, 1'b1);
            check("bp_bresp", bresp, e1);
            tick();
        end
        e2 = model_write(8'h14, 32'h12121212, 4'hF);
        awaddr = 8'h14; wdata = 32'h12121212; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            check("bp_awready", awready, 1'b0);
            check("bp_wready", wready, 1'b0);
            check("bp_bresp_hold", bresp, e1);
            tick();
        end
        bready = 1;
        tick();
        check("bp_second_bvalid", bvalid, 1'b1);
        check("bp_second_bresp", bresp, e2);
        tick();
        bready = 0;
        check("bp_drain", bvalid, 1'b0);
        check("bp_regs", regs, model_vec());

        // Read backpressure, then four back-to-back beats.
        rready = 0; araddr = 8'h0C; arvalid = 1;
        tick();
        check("rbp_rvalid", rvalid, 1'b1);
        araddr = 8'h10;
        for (int i = 0; i < 3; i++) begin
            check("rbp_arready", arready, 1'b0);
            check("rbp_rdata", rdata, model[3]);
            tick();
        end
        rready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b2b_rvalid", rvalid, 1'b1);
            check("b2b_rdata", rdata, model[4 + i]);
            if (i < 3) araddr = 8'((5 + i) * 4);
            else arvalid = 0;
            tick();
        end
        check("b2b_done", rvalid, 1'b0);
        rready = 0;

        // Hardware write and bus commit on the same register in one cycle.
        hw_we = 16'h0002; hw_wdata = '0; hw_wdata[32 +: 32] = 32'hFFFFFFFF;
        awaddr = 8'h04; wdata = 32'h0; wstrb = 4'b0011; awvalid = 1; wvalid = 1; bready = 1;
        check("hwc_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 0; wvalid = 0; hw_we = '0;
        model[1] = 32'hFFFFFFFF;
        void'(model_write(8'h04, 32'h0, 4'b0011));
        check("hwc_reg1", regs[32 +: 32], 32'hFFFF0000);
        check("hwc_bresp", {bvalid, bresp}, 3'b100);
        tick();
        bready = 0;

        // Read handshaking in the same cycle as a write commit to the same register.
        old = model[2];
        awaddr = 8'h08; wdata = 32'hC0FFEE00; wstrb = 4'hF; araddr = 8'h08;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        void'(model_write(8'h08, 32'hC0FFEE00, 4'hF));
        check("rwc_rdata", rdata, old);
        check("rwc_reg2", regs[64 +: 32], model[2]);
        tick();
        bready = 0; rready = 0;

        // Random mix of bus writes, bus reads and hardware loads.
        for (int it = 0; it < 40; it++) begin
            int op = $urandom_range(0, 3);
            logic [7:0] a = 8'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
            if (op <= 1) begin
                write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                          $urandom_range(0, 3), "rnd_wr");
            end else if (op == 2) begin
                read_txn(a, "rnd_rd");
            end else begin
                k = $urandom_range(0, NREGS - 1);
                v = $urandom;
                hw_we[k] = 1'b1; hw_wdata[k*32 +: 32] = v;
                tick();
                hw_we = '0;
                model[k] = v;
                check("rnd_hw", regs, model_vec());
            end
        end

        // Reset while a response is pending and an address is held.
        awaddr = 8'h1C; wdata = 32'h31415926; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        wvalid = 0; awaddr = 8'h00;
        tick();
        awvalid = 0;
        check("mid_bvalid", bvalid, 1'b1);
        reset_n = 0;
        tick();
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_regs", regs, RSTV);
        reset_n = 1;
        #1;
        model_reset();
        check("mid_rst_awready", awready, 1'b1);
        tick();
        check("mid_no_resp", bvalid, 1'b0);
        write_txn(8'h00, 32'hA5A5A5A5, 4'hF, 0, 0, "post_mid");
        read_txn(8'h00, "post_mid_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
